// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator for a combinational ALU. Commands arrive on a valid/ready port,
//   are registered onto alu_a/alu_b/alu_op, and the ALU outputs are captured
//   one cycle later into a small result FIFO. That FIFO is drained over a
//   second valid/ready port. The block also keeps a saturating count of
//   captured responses and a sticky overflow bit.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_a, cmd_b, cmd_op payload
//   alu_a/b/op          registered operands and opcode to the ALU
//   alu_result/carry/overflow  combinational ALU outputs
//   rsp_valid/ready     response handshake; rsp_result, rsp_flags
//                       {div0, overflow, carry}, rsp_op payload
//   busy                EXEC in progress or FIFO non-empty
//   clr_stats           clears cmd_count and sticky_ovf
//   cmd_count           captured responses, saturating
//   sticky_ovf          OR of every captured overflow flag
//   dbg_state           current FSM state (0 = IDLE, 1 = EXEC)
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. A producer holds valid and payload steady
// until that transfer happens. Ready may depend on state, not on valid.

module alu_op_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [1:0]       rsp_op,
  output logic             busy,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cmd_count,
  output logic             sticky_ovf,
  output logic             dbg_state
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W  = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + 5;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic               div0_q, div0_d;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [CNT_W-1:0]   cmd_count_q, cmd_count_d;
  logic               sticky_q, sticky_d;

  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign fifo_full  = (fifo_cnt_q == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);

  // FSM next state and command-side outputs. Ready is forced low while reset
  // is asserted so nothing is accepted on the reset edge.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = rst_n && !fifo_full;
        accept    = cmd_valid && cmd_ready;
        if (accept) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          div0_d   = (cmd_op == OP_DIV) && (cmd_b == '0);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU has had a full cycle on the registered operands; capture now.
        // Room is guaranteed: acceptance required a free slot and no other
        // push can occur in between.
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop        = rsp_valid && rsp_ready;
  assign push_entry = {alu_result, div0_q, alu_overflow, alu_carry, alu_op_q};

  // FIFO pointer/count bookkeeping; simultaneous push and pop leave count alone.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Statistics. A push in the same cycle as clr_stats counts as the first
  // event after the clear, so it wins over the clear.
  always_comb begin
    cmd_count_d = cmd_count_q;
    sticky_d    = sticky_q;
    if (push) begin
      if (clr_stats) begin
        cmd_count_d = CNT_W'(1);
        sticky_d    = alu_overflow;
      end else begin
        cmd_count_d = (cmd_count_q == '1) ? cmd_count_q : cmd_count_q + CNT_W'(1);
        sticky_d    = sticky_q | alu_overflow;
      end
    end else if (clr_stats) begin
      cmd_count_d = '0;
      sticky_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      div0_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      cmd_count_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      div0_q      <= div0_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      cmd_count_q <= cmd_count_d;
      sticky_q    <= sticky_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  assign head_entry = fifo_mem[rd_ptr_q];

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rst_n && !fifo_empty;
  assign rsp_result = head_entry[ENTRY_W-1:5];
  assign rsp_flags  = head_entry[4:2];
  assign rsp_op     = head_entry[1:0];
  assign busy       = (state_q == ST_EXEC) || !fifo_empty;
  assign cmd_count  = cmd_count_q;
  assign sticky_ovf = sticky_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int W = 21;  // {result[15:0], flags[2:0], op[1:0]}

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [1:0]  cmd_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [1:0]  rsp_op;
  logic        busy;
  logic        clr_stats;
  logic [15:0] cmd_count;
  logic        sticky_ovf;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  alu_op_sequencer #(.WIDTH(16), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_op(rsp_op),
    .busy(busy), .clr_stats(clr_stats),
    .cmd_count(cmd_count), .sticky_ovf(sticky_ovf), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- combinational ALU environment ----------------
  always_comb begin
    logic [16:0] t;
    t            = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      2'b00: begin
        t            = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = t[15:0];
        alu_carry    = t[16];
        alu_overflow = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
      end
      2'b01: begin
        t            = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = t[15:0];
        alu_carry    = t[16];
        alu_overflow = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
      end
      2'b10: alu_result = alu_a * alu_b;
      default: alu_result = (alu_b == 16'h0000) ? 16'hFFFF : alu_a / alu_b;
    endcase
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got %0h with empty queue", {rsp_result, rsp_flags, rsp_op});
      end else begin
        check("rsp", 32'({rsp_result, rsp_flags, rsp_op}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                      input logic [15:0] er, input logic [2:0] ef, input bit exp_rsp);
    bit ok;
    ok        = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: cmd_ready=0 expected 1 within 40 cycles");
    end else if (exp_rsp) begin
      exp_q.push_back({er, ef, op});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    rsp_ready = 1'b0;
    clr_stats = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    check("rst_sticky", 32'(sticky_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: accept at N, rsp_valid visible after N+1.
    rsp_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b010, 1);
    @(negedge clk);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    check("exec_alu_a", 32'(alu_a), 32'h7FFF);
    check("exec_state", 32'(dbg_state), 32'd1);
    @(negedge clk);
    check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_idle();
    check("stat_count_1", 32'(cmd_count), 32'd1);
    check("stat_sticky_1", 32'(sticky_ovf), 32'd1);

    // Directed arithmetic vectors.
    send(16'h0000, 16'h0001, 2'b01, 16'hFFFF, 3'b001, 1);
    send(16'h0010, 16'h0000, 2'b11, 16'hFFFF, 3'b100, 1);
    send(16'h0100, 16'h0100, 2'b10, 16'h0000, 3'b000, 1);
    send(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 3'b001, 1);
    send(16'h8000, 16'h0001, 2'b01, 16'h7FFF, 3'b010, 1);
    send(16'h0064, 16'h0007, 2'b11, 16'h000E, 3'b000, 1);
    send(16'h0003, 16'h0005, 2'b10, 16'h000F, 3'b000, 1);
    wait_idle();
    check("stat_count_8", 32'(cmd_count), 32'd8);

    // Full FIFO: 4 accepted, 5th held off until a pop.
    rsp_ready = 1'b0;
    send(16'h0001, 16'h0010, 2'b00, 16'h0011, 3'b000, 1);
    send(16'h0002, 16'h0010, 2'b00, 16'h0012, 3'b000, 1);
    send(16'h0003, 16'h0010, 2'b00, 16'h0013, 3'b000, 1);
    send(16'h0004, 16'h0010, 2'b00, 16'h0014, 3'b000, 1);
    cmd_valid = 1'b1;
    cmd_a     = 16'h0005;
    cmd_b     = 16'h0010;
    cmd_op    = 2'b00;
    seen      = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1;
    end
    check("full_ready_low", 32'(seen), 32'd0);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("full_pop_cycle_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("after_pop_ready", 32'(cmd_ready), 32'd1);
    exp_q.push_back({16'h0015, 3'b000, 2'b00});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Simultaneous push and pop at count 2, across pointer wrap.
    rsp_ready = 1'b0;
    send(16'h0020, 16'h0001, 2'b00, 16'h0021, 3'b000, 1);
    send(16'h0030, 16'h0002, 2'b01, 16'h002E, 3'b000, 1);
    send(16'h0004, 16'h0004, 2'b10, 16'h0010, 3'b000, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    send(16'h0040, 16'h0002, 2'b11, 16'h0020, 3'b000, 1);
    send(16'h0050, 16'h0005, 2'b00, 16'h0055, 3'b000, 1);
    @(negedge clk);
    @(negedge clk);
    check("pushpop_full", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Statistics clear, alone and coinciding with a push.
    @(posedge clk);
    #1;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    @(negedge clk);
    check("clr_count", 32'(cmd_count), 32'd0);
    check("clr_sticky", 32'(sticky_ovf), 32'd0);
    @(posedge clk);
    #1;
    send(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b010, 1);
    wait_idle();
    check("ovf_sticky", 32'(sticky_ovf), 32'd1);
    send(16'h0001, 16'h0001, 2'b00, 16'h0002, 3'b000, 1);
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    @(negedge clk);
    check("clrpush_count", 32'(cmd_count), 32'd1);
    check("clrpush_sticky0", 32'(sticky_ovf), 32'd0);
    @(posedge clk);
    #1;
    send(16'h7FFF, 16'h7FFF, 2'b00, 16'hFFFE, 3'b010, 1);
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    @(negedge clk);
    check("clrpush_count2", 32'(cmd_count), 32'd1);
    check("clrpush_sticky1", 32'(sticky_ovf), 32'd1);
    @(posedge clk);
    #1;
    wait_idle();

    // Reset during EXEC drops the in-flight command.
    send(16'h1234, 16'h0034, 2'b01, 16'h1200, 3'b000, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("exec_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("exec_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    check("post_rst_alu_a", 32'(alu_a), 32'd0);
    check("post_rst_alu_b", 32'(alu_b), 32'd0);
    check("post_rst_count", 32'(cmd_count), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0005, 16'h0003, 2'b01, 16'h0002, 3'b000, 1);
    wait_idle();
    check("post_rst_count1", 32'(cmd_count), 32'd1);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
